// File: rtl/midi_pkg.sv
// Shared MIDI constants, state type and status-class helpers.
// Used by midi_out and midi_out_byte.
package midi_pkg;

    localparam int          MIDI_BAUD_CNT      = 3200;
    localparam logic [7:0]  MIDI_STATUS_MSB    = 8'h80;
    localparam logic [7:0]  MIDI_SYSCOM_BASE   = 8'hF0;
    localparam logic [7:0]  MIDI_REALTIME_BASE = 8'hF8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } midi_out_state_t;

    // Channel voice/mode status: 0x80..0xEF
    function automatic logic is_voice(input logic [7:0] s);
        return (s >= MIDI_STATUS_MSB) && (s < MIDI_SYSCOM_BASE);
    endfunction

    // System common status: 0xF0..0xF7
    function automatic logic is_syscom(input logic [7:0] s);
        return (s >= MIDI_SYSCOM_BASE) && (s < MIDI_REALTIME_BASE);
    endfunction

endpackage

// File: rtl/midi_out_byte.sv
// One-byte MIDI framer: baud counter plus LSB-first shifter.
// bit_idx: 0 = start, 1..8 = data, 9 = stop. BAUD_CNT must be >= 2.
module midi_out_byte
    import midi_pkg::*;
#(
    parameter int BAUD_CNT = MIDI_BAUD_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       tx_bit,
    output logic       bit_end,
    output logic [3:0] bit_idx,
    output logic       done
);

    localparam int             CW      = $clog2(BAUD_CNT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(BAUD_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          busy_q, busy_d;

    assign bit_end = busy_q && (cnt_q == CNT_MAX);
    assign done    = bit_end && (idx_q == 4'd9);
    assign busy    = busy_q;
    assign tx_bit  = shift_q[0];
    assign bit_idx = idx_q;

    // Next-state: start loads a byte; counter runs only while busy
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        if (start) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            idx_d   = 4'd0;
            shift_d = din;
        end else if (busy_q) begin
            if (bit_end) begin
                cnt_d = '0;
                idx_d = idx_q + 4'd1;
                if (idx_q != 4'd0)
                    shift_d = {1'b0, shift_q[7:1]};
                if (done) begin
                    busy_d = 1'b0;
                    idx_d  = 4'd0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Framer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            shift_q <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/midi_out.sv
// MIDI message transmitter: sequences up to 3 bytes through midi_out_byte.
// Optional running-status suppression: MIDI_OUT_RUNNING_STATUS_EN.
module midi_out
    import midi_pkg::*;
#(
    parameter int BAUD_CNT = MIDI_BAUD_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_valid,
    output logic       send_ready,
    input  logic [7:0] status_out,
    input  logic [7:0] data1_out,
    input  logic [7:0] data2_out,
    input  logic [1:0] bytes_cnt_out,
    output logic       midi_tx,
    output logic       tx_done
);

    midi_out_state_t state_q, state_d;
    logic [15:0]     msg_q, msg_d;
    logic [1:0]      left_q, left_d;
    logic            tx_done_q, tx_done_d;

    logic            byte_start;
    logic [7:0]      byte_din;
    logic            byte_busy;
    logic            byte_bit;
    logic            byte_bit_end;
    logic [3:0]      byte_idx;
    logic            byte_done;
    logic            supp;

    midi_out_byte #(
        .BAUD_CNT (BAUD_CNT)
    ) u_byte (
        .clk     (clk),
        .rst     (rst),
        .start   (byte_start),
        .din     (byte_din),
        .busy    (byte_busy),
        .tx_bit  (byte_bit),
        .bit_end (byte_bit_end),
        .bit_idx (byte_idx),
        .done    (byte_done)
    );

`ifdef MIDI_OUT_RUNNING_STATUS_EN
    logic [7:0] last_q, last_d;

    assign supp = (status_out == last_q) && is_voice(status_out)
                  && (bytes_cnt_out >= 2'd2);

    // Track last voice status; system common clears, realtime keeps
    always_comb begin
        last_d = last_q;
        if ((state_q == IDLE) && send_valid && (bytes_cnt_out != 2'd0)) begin
            if (is_voice(status_out))
                last_d = status_out;
            else if (is_syscom(status_out))
                last_d = 8'h00;
        end
    end

    // Last-status register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 8'h00;
        else      last_q <= last_d;
    end
`else
    assign supp = 1'b0;
`endif

    assign send_ready = (state_q == IDLE);
    assign tx_done    = tx_done_q;

    // Line level decoded from state and current shifter bit
    always_comb begin
        unique case (state_q)
            START:   midi_tx = 1'b0;
            DATA:    midi_tx = byte_bit | ~byte_busy;
            default: midi_tx = 1'b1;
        endcase
    end

    // Message sequencer: acceptance, byte chaining, completion
    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        left_d     = left_q;
        tx_done_d  = 1'b0;
        byte_start = 1'b0;
        byte_din   = msg_q[7:0];
        unique case (state_q)
            IDLE: begin
                if (send_valid) begin
                    if (bytes_cnt_out == 2'd0) begin
                        tx_done_d = 1'b1;
                    end else begin
                        byte_start = 1'b1;
                        state_d    = START;
                        if (supp) begin
                            byte_din = data1_out;
                            msg_d    = {8'h00, data2_out};
                            left_d   = bytes_cnt_out - 2'd2;
                        end else begin
                            byte_din = status_out;
                            msg_d    = {data2_out, data1_out};
                            left_d   = bytes_cnt_out - 2'd1;
                        end
                    end
                end
            end
            START: begin
                if (byte_bit_end)
                    state_d = DATA;
            end
            DATA: begin
                if (byte_bit_end && (byte_idx == 4'd8))
                    state_d = STOP;
            end
            STOP: begin
                if (byte_done) begin
                    if (left_q != 2'd0) begin
                        byte_start = 1'b1;
                        msg_d      = {8'h00, msg_q[15:8]};
                        left_d     = left_q - 2'd1;
                        state_d    = START;
                    end else begin
                        tx_done_d  = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            msg_q     <= 16'h0000;
            left_q    <= 2'd0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            left_q    <= left_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_midi_out.sv
// Directed bench for midi_out at BAUD_CNT = 16.
// Decodes the serial line at bit centres and checks timing/handshake.
module tb_midi_out;

    localparam int BC = 16;

    logic       clk;
    logic       rst;
    logic       send_valid;
    logic       send_ready;
    logic [7:0] status_out;
    logic [7:0] data1_out;
    logic [7:0] data2_out;
    logic [1:0] bytes_cnt_out;
    logic       midi_tx;
    logic       tx_done;

    int total;
    int bad;
    int done_at;
    logic line_s [0:1023];

    midi_out #(
        .BAUD_CNT (BC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .send_valid    (send_valid),
        .send_ready    (send_ready),
        .status_out    (status_out),
        .data1_out     (data1_out),
        .data2_out     (data2_out),
        .bytes_cnt_out (bytes_cnt_out),
        .midi_tx       (midi_tx),
        .tx_done       (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Send one message, record the line each cycle, verify framing.
    // poke > 0 pulses a 0xB0 message on send_valid at that cycle.
    task automatic xfer(input string tag, input logic [7:0] st,
                        input logic [7:0] d1, input logic [7:0] d2,
                        input logic [1:0] cnt, input int n,
                        input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input int poke);
        logic [7:0] exp_b [0:2];
        logic [7:0] got;
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        @(negedge clk);
        status_out    = st;
        data1_out     = d1;
        data2_out     = d2;
        bytes_cnt_out = cnt;
        send_valid    = 1'b1;
        @(posedge clk);
        #1;
        send_valid    = 1'b0;
        status_out    = 8'h5A;
        data1_out     = 8'hA5;
        data2_out     = 8'h3C;
        bytes_cnt_out = 2'd3;
        check({tag, "_ready1"}, send_ready, (n == 0));
        done_at = 0;
        for (int c = 1; c < 1000; c++) begin
            line_s[c] = midi_tx;
            if (tx_done) begin
                done_at = c;
                break;
            end
            if (c == poke) begin
                status_out    = 8'hB0;
                data1_out     = 8'h07;
                data2_out     = 8'h10;
                bytes_cnt_out = 2'd3;
                send_valid    = 1'b1;
            end
            if (c == poke + 1)
                send_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        check({tag, "_len"}, done_at, BC * 10 * n + 1);
        check({tag, "_tx1"}, line_s[1], (n == 0));
        check({tag, "_rdy_end"}, send_ready, 1);
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 8; k++)
                got[k] = line_s[(10 * j + 1 + k) * BC + BC / 2];
            check({tag, "_start"}, line_s[10 * j * BC + BC / 2], 0);
            check({tag, "_byte"}, got, exp_b[j]);
            check({tag, "_stop"}, line_s[(10 * j + 9) * BC + BC / 2], 1);
        end
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, tx_done, 0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        send_valid    = 1'b0;
        status_out    = 8'h00;
        data1_out     = 8'h00;
        data2_out     = 8'h00;
        bytes_cnt_out = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", midi_tx, 1);
        check("rst_ready", send_ready, 1);
        check("rst_done", tx_done, 0);
        @(negedge clk);
        rst = 1'b1;

        xfer("note_on", 8'h90, 8'h3C, 8'h64, 2'd3, 3,
             8'h90, 8'h3C, 8'h64, 0);
        xfer("prog", 8'hC0, 8'h05, 8'h77, 2'd2, 2,
             8'hC0, 8'h05, 8'h00, 0);

        xfer("rs_a", 8'h90, 8'h40, 8'h7F, 2'd3, 3,
             8'h90, 8'h40, 8'h7F, 0);
        xfer("rs_rt", 8'hF8, 8'h00, 8'h00, 2'd1, 1,
             8'hF8, 8'h00, 8'h00, 0);
`ifdef MIDI_OUT_RUNNING_STATUS_EN
        xfer("rs_b", 8'h90, 8'h40, 8'h00, 2'd3, 2,
             8'h40, 8'h00, 8'h00, 0);
`else
        xfer("rs_b", 8'h90, 8'h40, 8'h00, 2'd3, 3,
             8'h90, 8'h40, 8'h00, 0);
`endif
        xfer("rs_sc", 8'hF0, 8'h00, 8'h00, 2'd1, 1,
             8'hF0, 8'h00, 8'h00, 0);
        xfer("rs_c", 8'h90, 8'h40, 8'h00, 2'd3, 3,
             8'h90, 8'h40, 8'h00, 0);
        xfer("rs_one", 8'h90, 8'h11, 8'h22, 2'd1, 1,
             8'h90, 8'h00, 8'h00, 0);

        xfer("busy", 8'hE0, 8'h00, 8'h40, 2'd3, 3,
             8'hE0, 8'h00, 8'h40, 100);
        repeat (40) @(posedge clk);
        #1;
        check("busy_idle_tx", midi_tx, 1);
        check("busy_idle_rdy", send_ready, 1);

        xfer("zero", 8'h80, 8'h01, 8'h02, 2'd0, 0,
             8'h00, 8'h00, 8'h00, 0);

        @(negedge clk);
        status_out    = 8'h90;
        data1_out     = 8'h3C;
        data2_out     = 8'h64;
        bytes_cnt_out = 2'd3;
        send_valid    = 1'b1;
        @(posedge clk);
        #1;
        send_valid = 1'b0;
        repeat (70) @(posedge clk);
        #2;
        check("mid_bit3", midi_tx, 0);
        check("mid_busy", send_ready, 0);
        rst = 1'b0;
        #1;
        check("arst_tx", midi_tx, 1);
        check("arst_ready", send_ready, 1);
        check("arst_done", tx_done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_tx", midi_tx, 1);
        xfer("after_rst", 8'h90, 8'h3C, 8'h64, 2'd3, 3,
             8'h90, 8'h3C, 8'h64, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
